// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array output path.
//   DEFAULT_OUTPUT_BITWIDTH : default width of one mesh result lane
//   result_t                : signed result lane
//   clog2()                 : counter/pointer width helper (clog2(1) = 0)
package sys_array_pkg;

  localparam int DEFAULT_OUTPUT_BITWIDTH = 32;

  typedef logic signed [DEFAULT_OUTPUT_BITWIDTH-1:0] result_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/deskew_fifo.sv
// Synchronous FIFO for aligned result rows.
//   clk, rst_n   : clock, async active-low reset
//   push, wdata  : write request and row data
//   pop          : read request (ignored while empty)
//   rdata        : head row, zero while empty (no fall-through)
//   full, empty  : occupancy flags
//   almost_full  : registered, free entries <= AF_MARGIN
//   drop         : push refused this cycle (full and not popping)
module deskew_fifo
  import sys_array_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count, count_nxt;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem[rptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count       <= count_nxt;
      almost_full <= (CW'(DEPTH) - count_nxt) <= CW'(AF_MARGIN);
    end
  end

  // Storage needs no reset: rdata is gated while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/mesh_output_deskew.sv
// Re-aligns the column-skewed south-edge outputs of the Mesh into whole
// rows, buffers them and drains them over ready/valid.
//   clock, reset    : clock, async active-low reset
//   in_c, in_valid  : per-column Mesh results; column j lags column 0 by j
//   out_row         : aligned row at FIFO head (zero while empty)
//   out_valid       : FIFO non-empty
//   out_ready       : consumer takes head row
//   out_last        : head row closes a BLOCK_ROWS block
//   out_almost_full : free entries <= AF_MARGIN (Mesh cannot stall)
//   err_overflow    : sticky, aligned row dropped on full FIFO
//   err_misalign    : sticky, delayed lane valids disagreed
module mesh_output_deskew
  import sys_array_pkg::*;
#(
  parameter int COLS            = 4,
  parameter int OUTPUT_BITWIDTH = DEFAULT_OUTPUT_BITWIDTH,
  parameter int FIFO_DEPTH      = 8,
  parameter int AF_MARGIN       = 4,
  parameter int BLOCK_ROWS      = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [COLS-1:0][OUTPUT_BITWIDTH-1:0] in_c,
  input  logic [COLS-1:0]                      in_valid,
  output logic [COLS-1:0][OUTPUT_BITWIDTH-1:0] out_row,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 out_almost_full,
  output logic                                 err_overflow,
  output logic                                 err_misalign
);

  localparam int RW = (BLOCK_ROWS > 1) ? clog2(BLOCK_ROWS) : 1;

  logic [COLS-1:0]                      d_valid;
  logic [COLS-1:0][OUTPUT_BITWIDTH-1:0] d_data;
  logic                                 row_all, row_any, pop, empty, full, drop;
  logic [RW-1:0]                        rcnt;

  // Lane j waits COLS-1-j cycles so every lane lines up with the last column.
  for (genvar j = 0; j < COLS; j++) begin : g_lane
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign d_valid[j] = in_valid[j];
      assign d_data[j]  = in_c[j];
    end else begin : g_dly
      logic [D-1:0]                      vld_pipe;
      logic [D-1:0][OUTPUT_BITWIDTH-1:0] dat_pipe;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          vld_pipe <= '0;
          dat_pipe <= '0;
        end else begin
          vld_pipe[0] <= in_valid[j];
          // Idle slots carry zero so the data chain does not toggle.
          dat_pipe[0] <= in_valid[j] ? in_c[j] : '0;
          for (int k = 1; k < D; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            dat_pipe[k] <= dat_pipe[k-1];
          end
        end
      end
      assign d_valid[j] = vld_pipe[D-1];
      assign d_data[j]  = dat_pipe[D-1];
    end
  end

  assign row_all   = &d_valid;
  assign row_any   = |d_valid;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid & (rcnt == RW'(BLOCK_ROWS - 1));

  deskew_fifo #(
    .WIDTH     (COLS * OUTPUT_BITWIDTH),
    .DEPTH     (FIFO_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .clk         (clock),
    .rst_n       (reset),
    .push        (row_all),
    .wdata       (d_data),
    .pop         (pop),
    .rdata       (out_row),
    .full        (full),
    .empty       (empty),
    .almost_full (out_almost_full),
    .drop        (drop)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt         <= '0;
      err_overflow <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      if (pop) rcnt <= (rcnt == RW'(BLOCK_ROWS - 1)) ? '0 : rcnt + RW'(1);
      if (drop) err_overflow <= 1'b1;
      // A partial row is discarded rather than pushed with holes in it.
      if (row_any & ~row_all) err_misalign <= 1'b1;
    end
  end

  // full is implied by drop; kept visible for debug.
  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_mesh_output_deskew.sv
module tb_mesh_output_deskew;
  import sys_array_pkg::*;

  localparam int COLS  = 4;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 4;
  localparam int BR    = 4;

  typedef logic [COLS-1:0][W-1:0] row_t;

  logic                   clock;
  logic                   reset = 1'b0;
  logic [COLS-1:0][W-1:0] in_c = '0;
  logic [COLS-1:0]        in_valid = '0;
  row_t                   out_row;
  logic                   out_valid, out_ready = 1'b0, out_last, out_almost_full;
  logic                   err_overflow, err_misalign;

  mesh_output_deskew #(
    .COLS(COLS), .OUTPUT_BITWIDTH(W), .FIFO_DEPTH(DEPTH),
    .AF_MARGIN(AF), .BLOCK_ROWS(BR)
  ) dut (
    .clock(clock), .reset(reset), .in_c(in_c), .in_valid(in_valid),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_almost_full(out_almost_full),
    .err_overflow(err_overflow), .err_misalign(err_misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [COLS*W-1:0] act,
                     input logic [COLS*W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A row is complete when lane j was valid exactly COLS-1-j cycles ago.
  bit   [COLS-1:0] hv [COLS];
  row_t            hd [COLS];
  row_t            mq [$];
  int              m_rcnt = 0;
  bit              m_ovf = 0, m_mis = 0, m_af = 0;

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        for (int k = 0; k < COLS; k++) begin hv[k] = '0; hd[k] = '0; end
        mq.delete();
        m_rcnt = 0; m_ovf = 0; m_mis = 0; m_af = 0;
      end else begin
        bit   all, any, full, pop;
        row_t row, dummy;
        for (int k = COLS-1; k > 0; k--) begin hv[k] = hv[k-1]; hd[k] = hd[k-1]; end
        hv[0] = in_valid; hd[0] = in_c;
        all = 1; any = 0; row = '0;
        for (int j = 0; j < COLS; j++) begin
          all = all & hv[COLS-1-j][j];
          any = any | hv[COLS-1-j][j];
          row[j] = hd[COLS-1-j][j];
        end
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && out_ready;
        if (any && !all) m_mis = 1;
        if (pop) begin dummy = mq.pop_front(); m_rcnt = (m_rcnt + 1) % BR; end
        if (all) begin
          if (!full || pop) mq.push_back(row);
          else m_ovf = 1;
        end
        m_af = (DEPTH - mq.size()) <= AF;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      bit   ev;
      row_t er;
      @(negedge clock);
      ev = mq.size() > 0;
      er = ev ? mq[0] : '0;
      chk("m_valid", out_valid, ev);
      chk("m_row", out_row, er);
      chk("m_last", out_last, ev && (m_rcnt == BR-1));
      chk("m_afull", out_almost_full, m_af);
      chk("m_ovf", err_overflow, m_ovf);
      chk("m_mis", err_misalign, m_mis);
    end
  end

  int first_vld = -1;
  initial forever begin
    @(negedge clock);
    if (out_valid && first_vld < 0) first_vld = cyc;
  end

  // ---------------- stimulus helpers ----------------
  int t0 = 0;

  function automatic row_t exp_row(input int r, input int base);
    row_t x;
    for (int j = 0; j < COLS; j++) x[j] = W'(base + 10*r + j);
    return x;
  endfunction

  task automatic drive_cycle(input int c, input int n, input int base);
    for (int j = 0; j < COLS; j++) begin
      int r;
      r = c - j;
      in_valid[j] = (r >= 0) && (r < n);
      in_c[j]     = in_valid[j] ? W'(base + 10*r + j) : '0;
    end
  endtask

  // Skewed rows: lane j of row r at cycle r+j. Optionally raise out_ready
  // for exactly one cycle at index rdy_at.
  task automatic push_rows(input int n, input int base, input int rdy_at);
    for (int c = 0; c < n + COLS - 1; c++) begin
      @(negedge clock);
      if (c == 0) t0 = cyc;
      drive_cycle(c, n, base);
      if (c == rdy_at) out_ready = 1'b1;
    end
    @(negedge clock);
    in_valid = '0; in_c = '0;
    if (rdy_at >= 0) out_ready = 1'b0;
  endtask

  task automatic drain_check(input int first_r, input int n, input int base);
    for (int r = first_r; r < first_r + n; r++) begin
      int t;
      t = 0;
      @(negedge clock);
      while (!out_valid && t < 50) begin @(negedge clock); t++; end
      chk("drain_timeout", t < 50, 1'b1);
      chk("drain_row", out_row, exp_row(r, base));
      out_ready = 1'b1;
    end
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = '0; in_c = '0; out_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int pops, seen, t;
    logic [7:0] mask;
    result_t neg;

    repeat (3) @(negedge clock);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_row", out_row, '0);
    chk("rst_af", out_almost_full, 1'b0);
    reset = 1'b1;

    // 1/2: alignment, latency, back-pressure and in-order drain
    first_vld = -1;
    push_rows(4, 0, -1);
    chk("t1_latency", first_vld - t0, 4);
    chk("t1_head", out_row, 128'h00000003_00000002_00000001_00000000);
    chk("t2_afull", out_almost_full, 1'b1);
    repeat (5) @(negedge clock);
    chk("t2_retained", out_row[3], 32'd3);
    drain_check(0, 4, 0);
    chk("t2_noerr", err_overflow, 1'b0);

    // 3: overflow drops the ninth row only
    do_reset();
    push_rows(9, 100, -1);
    chk("t3_ovf", err_overflow, 1'b1);
    chk("t3_af", out_almost_full, 1'b1);
    drain_check(0, 8, 100);
    chk("t3_empty", out_valid, 1'b0);
    // push and pop together while full
    do_reset();
    push_rows(9, 200, 11);
    chk("t3_simul_noerr", err_overflow, 1'b0);
    drain_check(1, 8, 200);

    // 4: lane 2 one cycle early
    do_reset();
    for (int c = 0; c < COLS; c++) begin
      @(negedge clock);
      for (int j = 0; j < COLS; j++) begin
        int tg;
        tg = (j == 2) ? 1 : j;
        in_valid[j] = (c == tg);
        in_c[j]     = (c == tg) ? W'(500 + j) : '0;
      end
    end
    @(negedge clock);
    in_valid = '0; in_c = '0;
    repeat (3) @(negedge clock);
    chk("t4_mis", err_misalign, 1'b1);
    chk("t4_nopush", out_valid, 1'b0);
    push_rows(1, 600, -1);
    drain_check(0, 1, 600);
    chk("t4_sticky", err_misalign, 1'b1);
    do_reset();
    chk("t4_cleared", err_misalign, 1'b0);

    // 5: out_last on rows 3 and 7 under random ready
    do_reset();
    push_rows(8, 0, -1);
    pops = 0; mask = '0; t = 0;
    while (pops < 8 && t < 300) begin
      bit rdy;
      @(negedge clock);
      t++;
      rdy = 1'($urandom_range(0, 1));
      if (out_valid && rdy) begin
        if (out_last) mask[pops[2:0]] = 1'b1;
        chk("t5_row", out_row[0], 32'(10*pops));
        pops++;
      end
      out_ready = rdy;
    end
    @(negedge clock);
    out_ready = 1'b0;
    chk("t5_pops", pops, 8);
    chk("t5_lastmask", mask, 8'h88);

    // 6: reset with rows in FIFO and skew lines
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      drive_cycle(c, 5, 300);
    end
    @(negedge clock);
    chk("t6_three", out_valid, 1'b1);
    in_valid = '0; in_c = '0;
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_row", out_row, '0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("t6_nothing", seen, 0);
    push_rows(1, -1, -1);
    neg = -1;
    chk("t6_neg", out_row[0], $unsigned(neg));
    drain_check(0, 1, -1);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
